// File: rtl/seven_seg_multi_display.sv
// rtl/seven_seg_multi_display.sv - multi-digit hex/decimal seven-segment driver with double-dabble conversion
// Optional leading-zero blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_multi_display #(
   parameter int DIGITS = 6,
   parameter int WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [WIDTH-1:0]      value_i,
   input  logic                  load_i,
   input  logic                  mode_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  overflow_o,
   output logic [7*DIGITS-1:0]   hex_out_o
);

   localparam int NB_DEC = (WIDTH * 3) / 10 + 1;
   localparam int NB     = (DIGITS > NB_DEC) ? DIGITS : NB_DEC;
   localparam int BW     = 4 * NB;
   localparam int CW     = $clog2(WIDTH + 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      UPDATE
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    val_q, val_d;
   logic                mode_q, mode_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [7*DIGITS-1:0] stg_seg_q, stg_seg_d;
   logic                stg_ovf_q, stg_ovf_d;
   logic                pend_q, pend_d;
   logic [7*DIGITS-1:0] hex_q, hex_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;

   logic [BW-1:0]       bcd_adj;
   logic [3:0]          dig [DIGITS];
   logic                blank [DIGITS];
   logic [7*DIGITS-1:0] disp_seg;
   logic                disp_ovf;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   logic                lead;
`endif

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Double-dabble step: add 3 to every nibble >= 5 before shifting.
   always_comb begin
      bcd_adj = '0;
      for (int k = 0; k < NB; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         else                         bcd_adj[4*k +: 4] = bcd_q[4*k +: 4];
      end
   end

   always_comb begin
      disp_seg = '1;
      if (mode_q) disp_ovf = |(bcd_q >> (4 * DIGITS));
      else        disp_ovf = |(val_q >> (4 * DIGITS));
      for (int k = 0; k < DIGITS; k++) begin
         dig[k]   = mode_q ? bcd_q[4*k +: 4] : 4'(val_q >> (4 * k));
         blank[k] = 1'b0;
      end
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      lead = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         if (dig[k] != 4'd0) lead = 1'b0;
         blank[k] = lead;
      end
`endif
      for (int k = 0; k < DIGITS; k++) begin
         if (disp_ovf)      disp_seg[7*k +: 7] = SEG_DASH;
         else if (blank[k]) disp_seg[7*k +: 7] = SEG_BLANK;
         else               disp_seg[7*k +: 7] = glyph(dig[k]);
      end
   end

   always_comb begin
      state_d   = state_q;
      val_d     = val_q;
      mode_d    = mode_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      stg_seg_d = stg_seg_q;
      stg_ovf_d = stg_ovf_q;
      pend_d    = 1'b0;
      hex_d     = hex_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;

      // The staged result is committed one cycle after UPDATE so the FSM is already free again.
      if (pend_q) begin
         hex_d  = stg_seg_q;
         ovf_d  = stg_ovf_q;
         done_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (load_i) begin
               val_d   = value_i;
               mode_d  = mode_i;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = mode_i ? CONVERT : UPDATE;
            end
         end
         CONVERT: begin
            bcd_d = (bcd_adj << 1) | BW'(val_q[WIDTH-1]);
            val_d = val_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = UPDATE;
         end
         UPDATE: begin
            stg_seg_d = disp_seg;
            stg_ovf_d = disp_ovf;
            pend_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         val_q     <= '0;
         mode_q    <= 1'b0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         stg_seg_q <= '1;
         stg_ovf_q <= 1'b0;
         pend_q    <= 1'b0;
         hex_q     <= '1;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         val_q     <= val_d;
         mode_q    <= mode_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         stg_seg_q <= stg_seg_d;
         stg_ovf_q <= stg_ovf_d;
         pend_q    <= pend_d;
         hex_q     <= hex_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign overflow_o = ovf_q;
   assign hex_out_o  = hex_q;

endmodule
